// File: rtl/bsg_dff_rr_share.sv
// Shared output register fed by els_p requesters under round-robin arbitration.
// Captures one payload per cycle; the consumer drains it with yumi_i.
module bsg_dff_rr_share #(
    parameter  int width_p   = 64,
    parameter  int els_p     = 4,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [lg_els_lp-1:0]       tag_o,
    input  logic                       yumi_i
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic [lg_els_lp:0] els_w = (lg_els_lp+1)'(els_p);

    state_e                 state_reg, state_next;
    logic [width_p-1:0]     data_reg, data_next;
    logic [lg_els_lp-1:0]   tag_reg, tag_next;
    logic [lg_els_lp-1:0]   last_reg, last_next;

    logic [width_p-1:0]     data_arr [els_p];
    logic [lg_els_lp-1:0]   cand_idx [els_p];
    logic [els_p-1:0]       req_rot;

    logic                   rdy;
    logic                   grant_any;
    logic                   grant;
    logic [lg_els_lp-1:0]   grant_idx;

    genvar gi;

    generate
        for (gi = 0; gi < els_p; gi++) begin : g_unpack
            assign data_arr[gi] = data_i[gi*width_p +: width_p];
        end
    endgenerate

    // Slot gi of req_rot is the requester that sits gi+1 places after last_reg.
    generate
        for (gi = 0; gi < els_p; gi++) begin : g_rot
            localparam logic [lg_els_lp:0] offset = (lg_els_lp+1)'(gi + 1);
            logic [lg_els_lp:0] sum;
            assign sum          = {1'b0, last_reg} + offset;
            assign cand_idx[gi] = (sum >= els_w) ? lg_els_lp'(sum - els_w)
                                                 : sum[lg_els_lp-1:0];
            assign req_rot[gi]  = v_i[cand_idx[gi]];
        end
    endgenerate

    // Lowest rotated slot wins, i.e. the first requester after the last grant.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = els_p - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
    end

    assign rdy   = (state_reg == EMPTY) | yumi_i;
    assign grant = rdy & grant_any & ~reset_i;

    generate
        for (gi = 0; gi < els_p; gi++) begin : g_yumi
            assign yumi_o[gi] = grant & (grant_idx == lg_els_lp'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        tag_next   = tag_reg;
        last_next  = last_reg;
        if (grant) begin
            data_next = data_arr[grant_idx];
            tag_next  = grant_idx;
            last_next = grant_idx;
        end
        case (state_reg)
            EMPTY: begin
                if (grant)
                    state_next = FULL;
            end
            FULL: begin
                if (yumi_i && !grant)
                    state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            tag_reg   <= '0;
            last_reg  <= lg_els_lp'(els_p - 1);
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            tag_reg   <= tag_next;
            last_reg  <= last_next;
        end
    end

    assign v_o    = (state_reg == FULL);
    assign data_o = data_reg;
    assign tag_o  = tag_reg;

endmodule

// File: tb/tb_bsg_dff_rr_share.sv
// Bench for bsg_dff_rr_share: directed vector table, then random traffic
// checked against a queue-based round-robin model.
module tb_bsg_dff_rr_share;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int LG = 2;

    logic               clk = 1'b0;
    logic               reset_i;
    logic [N-1:0]       v_i;
    logic [N*W-1:0]     data_i;
    logic [N-1:0]       yumi_o;
    logic               v_o;
    logic [W-1:0]       data_o;
    logic [LG-1:0]      tag_o;
    logic               yumi_i;

    int total = 0;
    int bad   = 0;

    bsg_dff_rr_share #(.width_p(W), .els_p(N)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .yumi_o  (yumi_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .tag_o   (tag_o),
        .yumi_i  (yumi_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] v;
        logic         y;
        logic [N-1:0] exp_yumi;
        logic         exp_v;
        int           exp_tag;
        logic         exp_zero;
    } vec_t;

    vec_t         vecs [23];
    logic [W-1:0] fixed_data [N];
    logic [W-1:0] cur_data [N];

    task automatic drive_data();
        for (int i = 0; i < N; i++)
            data_i[i*W +: W] = cur_data[i];
    endtask

    // Reference model state for the random phase
    int           last_g;
    logic         pend [N];
    int           waitc [N];
    logic [W-1:0] q_data [$];
    int           q_tag [$];

    initial begin
        for (int i = 0; i < N; i++) begin
            fixed_data[i] = {32'hDEAD_BEEF, 32'h0000_0001 + 32'(i)};
            cur_data[i]   = fixed_data[i];
        end
        //          rst   v        y     yumi     v     tag zero
        vecs[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 1'b1};
        vecs[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 1'b0};
        vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b0};
        vecs[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b0};
        vecs[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b0};
        vecs[10] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b0};
        vecs[11] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b0};
        vecs[12] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
        vecs[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1, 1'b0};
        vecs[14] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 3, 1'b0};
        vecs[15] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 1'b0};
        vecs[16] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b1, 0, 1'b0};
        vecs[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b0};
        vecs[18] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 0, 1'b1};
        vecs[19] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
        vecs[20] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
        vecs[21] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};
        vecs[22] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1, 1'b0};

        reset_i = 1'b1;
        v_i     = '0;
        yumi_i  = 1'b0;
        drive_data();
        @(posedge clk);

        // Directed table
        for (int r = 0; r < 23; r++) begin
            @(negedge clk);
            reset_i = vecs[r].rst;
            v_i     = vecs[r].v;
            yumi_i  = vecs[r].y;
            #1;
            check($sformatf("vec%0d yumi_o", r), 64'(yumi_o), 64'(vecs[r].exp_yumi));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d v_o", r), 64'(v_o), 64'(vecs[r].exp_v));
            check($sformatf("vec%0d tag_o", r), 64'(tag_o), 64'(vecs[r].exp_tag));
            check($sformatf("vec%0d data_o", r), data_o,
                  vecs[r].exp_zero ? 64'h0 : fixed_data[vecs[r].exp_tag]);
            $display("vec %0d: rst=%b v_i=%b yumi_i=%b -> v_o=%b tag_o=%0d data_o=%h",
                     r, vecs[r].rst, vecs[r].v, vecs[r].y, v_o, tag_o, data_o);
        end

        // Random phase from a fresh reset
        @(negedge clk);
        reset_i = 1'b1;
        v_i     = '0;
        yumi_i  = 1'b0;
        @(posedge clk);
        last_g = N - 1;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            waitc[i] = 0;
        end

        for (int c = 0; c < 4000; c++) begin
            int g;
            logic full;
            logic [N-1:0] exp_y;
            @(negedge clk);
            reset_i = 1'b0;
            full = (q_tag.size() != 0);
            for (int i = 0; i < N; i++) begin
                if (pend[i] && ($urandom % 16 == 0)) begin
                    pend[i]  = 1'b0;
                    waitc[i] = 0;
                end else if (!pend[i] && ($urandom % 2 == 0)) begin
                    pend[i]     = 1'b1;
                    cur_data[i] = {$urandom, $urandom};
                end
                v_i[i] = pend[i];
            end
            drive_data();
            yumi_i = full && ($urandom % 3 != 0);
            #1;
            check("rand v_o", 64'(v_o), 64'(full));
            if (yumi_i) begin
                check("rand data_o", data_o, q_data[0]);
                check("rand tag_o", 64'(tag_o), 64'(q_tag[0]));
                void'(q_data.pop_front());
                void'(q_tag.pop_front());
            end
            g = -1;
            if (!full || yumi_i) begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && pend[(last_g + k) % N])
                        g = (last_g + k) % N;
                end
            end
            exp_y = '0;
            if (g >= 0)
                exp_y[g] = 1'b1;
            check("rand yumi_o", 64'(yumi_o), 64'(exp_y));
            if (g >= 0) begin
                check("rand starve", 64'(waitc[g] <= N - 1), 64'd1);
                q_data.push_back(cur_data[g]);
                q_tag.push_back(g);
                for (int i = 0; i < N; i++)
                    if (pend[i] && i != g)
                        waitc[i]++;
                waitc[g] = 0;
                pend[g]  = 1'b0;
                last_g   = g;
            end
            if (c % 500 == 0)
                $display("rand cycle %0d: v_i=%b yumi_i=%b yumi_o=%b exp=%b",
                         c, v_i, yumi_i, yumi_o, exp_y);
            @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
